uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial receive front end of the UART peripheral.
- Oversamples the RX pin with the 16x enable from the baud-rate divisor and frames 8N1 characters, LSB first.
- Holds one received byte plus status flags (full, framing error, overrun) for the CPU-facing data/status registers.
- The CPU read of the data register is signalled back to the block as RD_ACK.

Parameters:
- DATA_BITS, 8, data bits per frame.
- OVERSAMPLE, 16, BAUD16_TICK pulses per bit period; must be an even power of two.
- SYNC_STAGES, 2, flip-flop stages in the RX metastability synchronizer.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- BAUD16_TICK  input  1  one-CLK-wide enable at OVERSAMPLE x baud, from the baud-rate divisor.
- RX  input  1  asynchronous serial line; idles high.
- RD_ACK  input  1  one-CLK pulse: CPU has read RX_DATA.
- RX_DATA  output  DATA_BITS  last accepted byte.
- RX_FULL  output  1  RX_DATA holds an unread byte.
- FRAME_ERR  output  1  byte in RX_DATA had a low stop bit.
- OVERRUN  output  1  sticky: a byte was dropped because RX_FULL was set.
- RX_BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - synchronizer flops = 1, state = IDLE, counters = 0.
  - RX_DATA = 0, RX_FULL = 0, FRAME_ERR = 0, OVERRUN = 0, RX_BUSY = 0.
  - Reset mid-frame abandons the frame with no output update.
- All FSM and counter activity is qualified by BAUD16_TICK. Only the synchronizer and RD_ACK handling run every CLK.
- rxs is the RX value after SYNC_STAGES flops; only rxs is used internally.
- Counters:
  - tick counter: log2(OVERSAMPLE) bits, wraps.
  - bit counter: counts 0..DATA_BITS-1.
- FSM states and transitions:
  - IDLE: on tick with rxs = 0, go to START and clear the tick counter.
  - START: count ticks. On the tick where the count reaches OVERSAMPLE/2-1 (mid start bit), sample rxs.
    - rxs = 1: false start (glitch); return to IDLE.
    - rxs = 0: go to DATA; clear the tick counter and bit counter.
  - DATA: on the tick where the count reaches OVERSAMPLE-1, sample rxs into the shift register MSB and shift right (LSB received first), then increment the bit counter.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: on the tick where the count reaches OVERSAMPLE-1, sample the stop bit and perform delivery (below).
    - Stop bit = 1: go to IDLE.
    - Stop bit = 0: go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rxs = 1, then go to IDLE. This prevents a break condition from retriggering start detection.
- Delivery, in the CLK after the stop-sample tick:
  - If RX_FULL = 0, or RD_ACK is high in that same cycle:
    - RX_DATA gets the shift register contents.
    - RX_FULL = 1.
    - FRAME_ERR = NOT stop bit.
  - Otherwise (RX_FULL = 1 and no RD_ACK): the new byte is discarded. RX_DATA and FRAME_ERR are unchanged, and OVERRUN is set.
  - A framing-error byte is still delivered.
- RD_ACK with no simultaneous delivery clears RX_FULL, FRAME_ERR and OVERRUN. RD_ACK while RX_FULL = 0 only clears OVERRUN.
- Latency:
  - Line start edge to IDLE-exit: SYNC_STAGES CLK plus up to one tick.
  - Stop-bit sample tick to RX_FULL = 1: exactly 1 CLK.
- Back-to-back frames: STOP exits at mid stop bit, so a start edge arriving immediately after the stop bit is detected.

Test Plan:
- Basic receive: BAUD16_TICK every 4 CLK; send 8N1 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first). Required: RX_DATA = 0xA5, RX_FULL = 1, FRAME_ERR = 0, RX_BUSY back to 0. Then pulse RD_ACK: RX_FULL = 0.
- False start: RX low for 3 ticks, then high. Required: back to IDLE, RX_FULL stays 0, no byte delivered. A following frame with 0x3C is received correctly.
- Framing error: send 0x55 with stop bit = 0, and hold RX low for 2 more bit times. Required: RX_DATA = 0x55, FRAME_ERR = 1, state WAIT_HIGH until RX returns high, no spurious second byte.
- Overrun: send 0x11 then 0x22 with no RD_ACK. Required: RX_DATA = 0x11, OVERRUN = 1. After RD_ACK: RX_FULL = 0 and OVERRUN = 0.
- Simultaneous: RD_ACK asserted in the exact delivery cycle of 0x22 while 0x11 is unread. Required: RX_DATA = 0x22, RX_FULL = 1, OVERRUN = 0.
- Reset mid-frame: assert RESET after 4 data bits of 0xF0. Required: all outputs 0 immediately. After release, a complete 0x0F frame is received as 0x0F.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: RX synchronizer, oversampled framing FSM and a
// single-byte holding register with full / framing-error / overrun status.
module uart_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 BAUD16_TICK,
    input  logic                 RX,
    input  logic                 RD_ACK,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_FULL,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 RX_BUSY
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_busy;
    logic                   r_deliver;
    logic                   r_stop_bit;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_full;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_rxs;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= RX;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // Framing FSM; every transition is gated by the oversample tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b0;
            r_deliver  <= 1'b0;
            r_stop_bit <= 1'b0;
        end else begin
            r_deliver <= 1'b0;
            if (BAUD16_TICK) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rxs) begin
                            r_state    <= START;
                            r_tick_cnt <= '0;
                            r_busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (r_tick_cnt == TICK_MID) begin
                            if (w_rxs) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state    <= DATA;
                                r_tick_cnt <= '0;
                                r_bit_cnt  <= '0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        if (r_tick_cnt == TICK_LAST) begin
                            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state   <= STOP;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        if (r_tick_cnt == TICK_LAST) begin
                            r_stop_bit <= w_rxs;
                            r_deliver  <= 1'b1;
                            if (w_rxs) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A read acknowledged in the delivery cycle frees the slot for the new byte.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data      <= '0;
            r_full      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_deliver) begin
            if (!r_full || RD_ACK) begin
                r_data      <= r_shift;
                r_full      <= 1'b1;
                r_frame_err <= !r_stop_bit;
                if (RD_ACK) begin
                    r_overrun <= 1'b0;
                end
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (RD_ACK) begin
            r_full      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign RX_DATA   = r_data;
    assign RX_FULL   = r_full;
    assign FRAME_ERR = r_frame_err;
    assign OVERRUN   = r_overrun;
    assign RX_BUSY   = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: tick every 4 CLK, 64 CLK per bit.
module tb_uart_receiver;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int tcnt    = 0;

    localparam int BIT_CLKS = 64;

    uart_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .BAUD16_TICK(tick),
        .RX         (rx),
        .RD_ACK     (rd_ack),
        .RX_DATA    (rx_data),
        .RX_FULL    (rx_full),
        .FRAME_ERR  (frame_err),
        .OVERRUN    (overrun),
        .RX_BUSY    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        rd_ack = 1'b0;
        idle(3);
        check("rst_data",    32'(rx_data),   32'h00);
        check("rst_full",    32'(rx_full),   32'h0);
        check("rst_ferr",    32'(frame_err), 32'h0);
        check("rst_ovr",     32'(overrun),   32'h0);
        check("rst_busy",    32'(rx_busy),   32'h0);
        rst = 1'b0;
        idle(10);

        // Basic receive
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("basic_data",  32'(rx_data),   32'hA5);
        check("basic_full",  32'(rx_full),   32'h1);
        check("basic_ferr",  32'(frame_err), 32'h0);
        check("basic_busy",  32'(rx_busy),   32'h0);
        pulse_ack();
        idle(2);
        check("basic_ack_full", 32'(rx_full), 32'h0);

        // False start, then a real frame
        rx = 1'b0;
        idle(12);
        rx = 1'b1;
        idle(100);
        check("fs_busy",     32'(rx_busy),   32'h0);
        check("fs_full",     32'(rx_full),   32'h0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("fs_data",     32'(rx_data),   32'h3C);
        check("fs_full2",    32'(rx_full),   32'h1);
        check("fs_ferr",     32'(frame_err), 32'h0);
        pulse_ack();
        idle(2);

        // Framing error with a held break
        send_frame(8'h55, 1'b0);
        check("fe_data",     32'(rx_data),   32'h55);
        check("fe_ferr",     32'(frame_err), 32'h1);
        check("fe_full",     32'(rx_full),   32'h1);
        check("fe_busy_wh",  32'(rx_busy),   32'h1);
        idle(2 * BIT_CLKS);
        check("fe_busy_brk", 32'(rx_busy),   32'h1);
        check("fe_no_ovr",   32'(overrun),   32'h0);
        check("fe_data2",    32'(rx_data),   32'h55);
        rx = 1'b1;
        idle(20);
        check("fe_busy_end", 32'(rx_busy),   32'h0);
        check("fe_no_ovr2",  32'(overrun),   32'h0);
        pulse_ack();
        idle(2);
        check("fe_ack_ferr", 32'(frame_err), 32'h0);
        check("fe_ack_full", 32'(rx_full),   32'h0);

        // Overrun
        send_frame(8'h11, 1'b1);
        idle(20);
        send_frame(8'h22, 1'b1);
        idle(20);
        check("ovr_data",    32'(rx_data),   32'h11);
        check("ovr_flag",    32'(overrun),   32'h1);
        check("ovr_full",    32'(rx_full),   32'h1);
        pulse_ack();
        idle(2);
        check("ovr_ack_full", 32'(rx_full),  32'h0);
        check("ovr_ack_flag", 32'(overrun),  32'h0);

        // RD_ACK in the exact delivery cycle of the second byte
        send_frame(8'h11, 1'b1);
        idle(20);
        fork
            send_frame(8'h22, 1'b1);
            begin
                int n;
                n = 0;
                while (!rx_busy && n < 2000) begin @(negedge clk); n++; end
                while (rx_busy && n < 2000) begin @(negedge clk); n++; end
                if (n >= 2000) check("sim_timeout", 32'(n), 32'h0);
                else pulse_ack();
            end
        join
        idle(20);
        check("sim_data",    32'(rx_data),   32'h22);
        check("sim_full",    32'(rx_full),   32'h1);
        check("sim_ovr",     32'(overrun),   32'h0);
        check("sim_ferr",    32'(frame_err), 32'h0);

        // Reset mid-frame with an unread byte pending
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        check("mr_busy_pre", 32'(rx_busy),   32'h1);
        rst = 1'b1;
        #1;
        check("mr_data",     32'(rx_data),   32'h00);
        check("mr_full",     32'(rx_full),   32'h0);
        check("mr_ferr",     32'(frame_err), 32'h0);
        check("mr_ovr",      32'(overrun),   32'h0);
        check("mr_busy",     32'(rx_busy),   32'h0);
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(BIT_CLKS);
        check("mr_idle_full", 32'(rx_full),  32'h0);
        send_frame(8'h0F, 1'b1);
        idle(20);
        check("mr_rx_data",  32'(rx_data),   32'h0F);
        check("mr_rx_full",  32'(rx_full),   32'h1);
        check("mr_rx_ferr",  32'(frame_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
